// File: rtl/rename_map_unit.sv
// rename_map_unit: 4-wide register rename stage.
// Maps architectural sources/destinations of a 4-instruction group onto the
// physical register file, allocates destinations from a circular free list,
// tracks physical readiness, and keeps a retirement map for flush recovery.
module rename_map_unit #(
  parameter int NPHY  = 64,
  parameter int NARCH = 32,
  parameter int NFREE = NPHY - NARCH,
  localparam int PW   = $clog2(NPHY),
  localparam int AW   = $clog2(NARCH),
  localparam int FW   = $clog2(NFREE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          Stall,
  input  logic          In_Valid,
  input  logic          Inst1_Valid,
  input  logic [AW-1:0] Inst1_Rs1,
  input  logic [AW-1:0] Inst1_Rs2,
  input  logic [AW-1:0] Inst1_Rd,
  input  logic          Inst2_Valid,
  input  logic [AW-1:0] Inst2_Rs1,
  input  logic [AW-1:0] Inst2_Rs2,
  input  logic [AW-1:0] Inst2_Rd,
  input  logic          Inst3_Valid,
  input  logic [AW-1:0] Inst3_Rs1,
  input  logic [AW-1:0] Inst3_Rs2,
  input  logic [AW-1:0] Inst3_Rd,
  input  logic          Inst4_Valid,
  input  logic [AW-1:0] Inst4_Rs1,
  input  logic [AW-1:0] Inst4_Rs2,
  input  logic [AW-1:0] Inst4_Rd,
  output logic          Rename_Stall,
  output logic          Inst1_Valid_o,
  output logic [PW-1:0] Inst1_Phydst,
  output logic [PW-1:0] Inst1_Src1,
  output logic [PW-1:0] Inst1_Src2,
  output logic          Inst1_Src1_Wake,
  output logic          Inst1_Src2_Wake,
  output logic          Inst2_Valid_o,
  output logic [PW-1:0] Inst2_Phydst,
  output logic [PW-1:0] Inst2_Src1,
  output logic [PW-1:0] Inst2_Src2,
  output logic          Inst2_Src1_Wake,
  output logic          Inst2_Src2_Wake,
  output logic          Inst3_Valid_o,
  output logic [PW-1:0] Inst3_Phydst,
  output logic [PW-1:0] Inst3_Src1,
  output logic [PW-1:0] Inst3_Src2,
  output logic          Inst3_Src1_Wake,
  output logic          Inst3_Src2_Wake,
  output logic          Inst4_Valid_o,
  output logic [PW-1:0] Inst4_Phydst,
  output logic [PW-1:0] Inst4_Src1,
  output logic [PW-1:0] Inst4_Src2,
  output logic          Inst4_Src1_Wake,
  output logic          Inst4_Src2_Wake,
  input  logic          ALU0_Commit,
  input  logic [PW-1:0] ALU0_Phydst,
  input  logic          ALU1_Commit,
  input  logic [PW-1:0] ALU1_Phydst,
  input  logic          ALU2_Commit,
  input  logic [PW-1:0] ALU2_Phydst,
  input  logic          ALU3_Commit,
  input  logic [PW-1:0] ALU3_Phydst,
  input  logic          BU_Commit,
  input  logic [PW-1:0] BU_Phydst,
  input  logic          DU_Commit,
  input  logic [PW-1:0] DU_Phydst,
  input  logic          Commit_1,
  input  logic [PW-1:0] Commit_Phy_1,
  input  logic [AW-1:0] Commit_Rdst_1
);

  localparam int NSLOT = 4;
  localparam int NWB   = 6;

  // Slot and writeback inputs gathered into arrays
  logic          w_vld    [NSLOT];
  logic [AW-1:0] w_rs1    [NSLOT];
  logic [AW-1:0] w_rs2    [NSLOT];
  logic [AW-1:0] w_rd     [NSLOT];
  logic          w_wb_vld [NWB];
  logic [PW-1:0] w_wb_tag [NWB];

  assign w_vld[0] = Inst1_Valid;  assign w_rs1[0] = Inst1_Rs1;
  assign w_rs2[0] = Inst1_Rs2;    assign w_rd[0]  = Inst1_Rd;
  assign w_vld[1] = Inst2_Valid;  assign w_rs1[1] = Inst2_Rs1;
  assign w_rs2[1] = Inst2_Rs2;    assign w_rd[1]  = Inst2_Rd;
  assign w_vld[2] = Inst3_Valid;  assign w_rs1[2] = Inst3_Rs1;
  assign w_rs2[2] = Inst3_Rs2;    assign w_rd[2]  = Inst3_Rd;
  assign w_vld[3] = Inst4_Valid;  assign w_rs1[3] = Inst4_Rs1;
  assign w_rs2[3] = Inst4_Rs2;    assign w_rd[3]  = Inst4_Rd;

  assign w_wb_vld[0] = ALU0_Commit;  assign w_wb_tag[0] = ALU0_Phydst;
  assign w_wb_vld[1] = ALU1_Commit;  assign w_wb_tag[1] = ALU1_Phydst;
  assign w_wb_vld[2] = ALU2_Commit;  assign w_wb_tag[2] = ALU2_Phydst;
  assign w_wb_vld[3] = ALU3_Commit;  assign w_wb_tag[3] = ALU3_Phydst;
  assign w_wb_vld[4] = BU_Commit;    assign w_wb_tag[4] = BU_Phydst;
  assign w_wb_vld[5] = DU_Commit;    assign w_wb_tag[5] = DU_Phydst;

  // Architectural state
  logic [PW-1:0]   r_rat   [NARCH];
  logic [PW-1:0]   r_rrat  [NARCH];
  logic [PW-1:0]   r_free  [NFREE];
  logic [FW-1:0]   r_alloc_ptr;
  logic [FW-1:0]   r_retire_ptr;
  logic [FW-1:0]   r_tail;
  logic [FW:0]     r_free_count;
  logic [NPHY-1:0] r_ready;

  // Registered outputs
  logic          r_o_vld  [NSLOT];
  logic [PW-1:0] r_o_dst  [NSLOT];
  logic [PW-1:0] r_o_src1 [NSLOT];
  logic [PW-1:0] r_o_src2 [NSLOT];
  logic          r_o_wk1  [NSLOT];
  logic          r_o_wk2  [NSLOT];

  // Combinational rename results
  logic            w_accept;
  logic            w_commit;
  logic [NPHY-1:0] w_wb_hit;
  logic [NPHY-1:0] w_alloc_mask;
  logic            w_wr     [NSLOT];
  logic [PW-1:0]   w_new    [NSLOT];
  logic [2:0]      w_nalloc;
  logic [FW-1:0]   w_idx;
  logic [PW-1:0]   w_src1   [NSLOT];
  logic [PW-1:0]   w_src2   [NSLOT];
  logic            w_wake1  [NSLOT];
  logic            w_wake2  [NSLOT];

  assign Rename_Stall = (r_free_count < (FW+1)'(NSLOT));
  assign w_accept     = In_Valid & ~Stall & ~Rename_Stall;
  assign w_commit     = Commit_1 & (Commit_Rdst_1 != '0);

  // One-hot set of tags written back this cycle (tag 0 is always ready)
  always_comb begin
    w_wb_hit = '0;
    for (int unsigned i = 0; i < NWB; i++) begin
      if (w_wb_vld[i] && (w_wb_tag[i] != '0)) w_wb_hit[w_wb_tag[i]] = 1'b1;
    end
  end

  // Hand out free-list entries to destination-writing slots in slot order
  always_comb begin
    w_nalloc     = '0;
    w_alloc_mask = '0;
    w_idx        = r_alloc_ptr;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      w_wr[k]  = In_Valid & w_vld[k] & (w_rd[k] != '0);
      w_new[k] = '0;
      if (w_wr[k]) begin
        w_new[k] = r_free[w_idx];
        w_idx    = w_idx + 1'b1;
        w_nalloc = w_nalloc + 3'd1;
        if (w_accept) w_alloc_mask[w_new[k]] = 1'b1;
      end
    end
  end

  // Source lookup: RAT value unless an earlier slot of the group writes it
  always_comb begin
    for (int unsigned k = 0; k < NSLOT; k++) begin
      w_src1[k]  = r_rat[w_rs1[k]];
      w_wake1[k] = r_ready[w_src1[k]];
      w_src2[k]  = r_rat[w_rs2[k]];
      w_wake2[k] = r_ready[w_src2[k]];
      // later j overwrites earlier, so the newest producer wins
      for (int unsigned j = 0; j < NSLOT; j++) begin
        if (j < k && w_wr[j] && (w_rd[j] == w_rs1[k])) begin
          w_src1[k]  = w_new[j];
          w_wake1[k] = 1'b0;
        end
        if (j < k && w_wr[j] && (w_rd[j] == w_rs2[k])) begin
          w_src2[k]  = w_new[j];
          w_wake2[k] = 1'b0;
        end
      end
      w_wake1[k] = w_wake1[k] | w_wb_hit[w_src1[k]];
      w_wake2[k] = w_wake2[k] | w_wb_hit[w_src2[k]];
    end
  end

  // Free-list ring, retirement map, pointers and free count
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NFREE; i++) r_free[i] <= PW'(NARCH + i);
      for (int unsigned i = 0; i < NARCH; i++) r_rrat[i] <= PW'(i);
      r_alloc_ptr  <= '0;
      r_retire_ptr <= '0;
      r_tail       <= '0;
      r_free_count <= (FW+1)'(NFREE);
    end else begin
      if (w_commit) begin
        r_rrat[Commit_Rdst_1] <= Commit_Phy_1;
        r_free[r_tail]        <= r_rrat[Commit_Rdst_1];
        r_tail                <= r_tail + 1'b1;
        r_retire_ptr          <= r_retire_ptr + 1'b1;
      end
      if (flush) begin
        // recovery point includes a commit retiring in the same cycle
        r_alloc_ptr  <= r_retire_ptr + FW'(w_commit);
        r_free_count <= (FW+1)'(NFREE);
      end else begin
        if (w_accept) r_alloc_ptr <= r_alloc_ptr + FW'(w_nalloc);
        r_free_count <= r_free_count + (FW+1)'(w_commit)
                        - (FW+1)'(w_accept ? w_nalloc : 3'd0);
      end
    end
  end

  // Speculative map: restored from the retirement map on flush
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NARCH; i++) r_rat[i] <= PW'(i);
    end else if (flush) begin
      for (int unsigned i = 0; i < NARCH; i++)
        r_rat[i] <= (w_commit && (Commit_Rdst_1 == AW'(i))) ? Commit_Phy_1 : r_rrat[i];
    end else if (w_accept) begin
      for (int unsigned k = 0; k < NSLOT; k++)
        if (w_wr[k]) r_rat[w_rd[k]] <= w_new[k];
    end
  end

  // Busy table: writebacks set ready, fresh allocations clear it
  always_ff @(posedge clk) begin
    if (rst || flush) r_ready <= '1;
    else              r_ready <= (r_ready | w_wb_hit) & ~w_alloc_mask;
  end

  // Output register: load on accept, hold under Stall with wake bypass
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NSLOT; k++) begin
        r_o_vld[k]  <= 1'b0;
        r_o_dst[k]  <= '0;
        r_o_src1[k] <= '0;
        r_o_src2[k] <= '0;
        r_o_wk1[k]  <= 1'b0;
        r_o_wk2[k]  <= 1'b0;
      end
    end else if (flush) begin
      for (int unsigned k = 0; k < NSLOT; k++) r_o_vld[k] <= 1'b0;
    end else if (w_accept) begin
      for (int unsigned k = 0; k < NSLOT; k++) begin
        r_o_vld[k]  <= w_vld[k];
        r_o_dst[k]  <= w_new[k];
        r_o_src1[k] <= w_src1[k];
        r_o_src2[k] <= w_src2[k];
        r_o_wk1[k]  <= w_wake1[k];
        r_o_wk2[k]  <= w_wake2[k];
      end
    end else if (Stall) begin
      for (int unsigned k = 0; k < NSLOT; k++) begin
        r_o_wk1[k] <= r_o_wk1[k] | w_wb_hit[r_o_src1[k]];
        r_o_wk2[k] <= r_o_wk2[k] | w_wb_hit[r_o_src2[k]];
      end
    end else begin
      for (int unsigned k = 0; k < NSLOT; k++) r_o_vld[k] <= 1'b0;
    end
  end

  assign Inst1_Valid_o = r_o_vld[0];  assign Inst1_Phydst = r_o_dst[0];
  assign Inst1_Src1    = r_o_src1[0]; assign Inst1_Src2   = r_o_src2[0];
  assign Inst1_Src1_Wake = r_o_wk1[0]; assign Inst1_Src2_Wake = r_o_wk2[0];
  assign Inst2_Valid_o = r_o_vld[1];  assign Inst2_Phydst = r_o_dst[1];
  assign Inst2_Src1    = r_o_src1[1]; assign Inst2_Src2   = r_o_src2[1];
  assign Inst2_Src1_Wake = r_o_wk1[1]; assign Inst2_Src2_Wake = r_o_wk2[1];
  assign Inst3_Valid_o = r_o_vld[2];  assign Inst3_Phydst = r_o_dst[2];
  assign Inst3_Src1    = r_o_src1[2]; assign Inst3_Src2   = r_o_src2[2];
  assign Inst3_Src1_Wake = r_o_wk1[2]; assign Inst3_Src2_Wake = r_o_wk2[2];
  assign Inst4_Valid_o = r_o_vld[3];  assign Inst4_Phydst = r_o_dst[3];
  assign Inst4_Src1    = r_o_src1[3]; assign Inst4_Src2   = r_o_src2[3];
  assign Inst4_Src1_Wake = r_o_wk1[3]; assign Inst4_Src2_Wake = r_o_wk2[3];

endmodule

// File: doc/rename_map_unit.md
Name: rename_map_unit

Overview:
4-wide register-rename stage placed directly upstream of the issue window. Each cycle it maps the architectural sources and destinations of one 4-instruction group onto the 64-entry physical register file. It allocates new physical destinations from a circular free list and produces the per-source ready (Wake) bits from a physical busy table. It also consumes the issue window's in-order commit port to maintain a retirement map and recover on flush.

Parameters:
NPHY, 64, number of physical registers (6-bit tags).
NARCH, 32, number of architectural registers (5-bit).
NFREE, NPHY-NARCH = 32, free-list depth.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
flush  in  1  pipeline flush (branch mispredict).
Stall  in  1  downstream cannot accept; high when the issue window is full or stalled.
In_Valid  in  1  group valid; per-slot validity is given by InstN_Valid.
InstN_Valid, N=1..4  in  1  slot valid.
InstN_Rs1, InstN_Rs2, InstN_Rd, N=1..4  in  5  architectural sources and destination; Rd=0 means no destination.
Rename_Stall  out  1  high when free_count < 4; upstream must hold the group.
InstN_Valid_o  out  1  registered slot valid.
InstN_Phydst, InstN_Src1, InstN_Src2  out  6  registered physical tags.
InstN_Src1_Wake, InstN_Src2_Wake  out  1  registered source-ready bits.
ALU0..3_Commit, BU_Commit, DU_Commit  in  1  writeback strobes.
ALU0..3_Phydst, BU_Phydst, DU_Phydst  in  6  writeback tags.
Commit_1  in  1  in-order commit of one instruction.
Commit_Phy_1  in  6  committed physical destination.
Commit_Rdst_1  in  5  committed architectural destination.

Behaviour:
- accept = In_Valid & !Stall & !Rename_Stall. A group is renamed in the accept cycle and appears on the outputs the next cycle (1-cycle latency, registered).
- Architectural r0 always maps to phys 0. Phys 0 is never allocated and is always ready. Rd=0, or an invalid slot, allocates nothing and drives Phydst=0.
- Reset/initial state: RAT[i]=RRAT[i]=i; free-list ring holds tags 32..63; alloc_ptr=retire_ptr=tail=0; free_count=32; busy table all-ready; all outputs 0.
- Allocation: valid slots with Rd!=0 take free-list entries in slot order 1→4, starting at alloc_ptr. alloc_ptr advances by the number taken (mod 32) and free_count decreases by the same amount.
- Source mapping, slot k: if an earlier slot j<k in the same group writes the same Rs, use the newest such slot's new tag with Wake=0. Otherwise use the RAT value, with Wake = busy-table ready.
- Wake bypass: a writeback in the rename cycle with a tag matching a source forces that Wake to 1. While outputs are held under Stall, their Wake bits OR in matching writebacks every cycle.
- RAT update: the last slot writing a given Rd wins. The busy table marks each new tag not-ready.
- Writeback: any *_Commit strobe marks its tag ready; tag 0 is ignored.
- Commit: if Commit_Rdst_1!=0, then old = RRAT[Rdst]; RRAT[Rdst] <= Commit_Phy_1; push old at tail; tail++; retire_ptr++; free_count++. Rdst=0 changes nothing.
- Simultaneous commit and allocate: free_count changes by +1 minus the number allocated.
- Flush: RAT <= RRAT, including any commit in the same cycle; alloc_ptr <= retire_ptr after that commit; free_count <= 32; busy table all-ready; output valids cleared. A group presented in the flush cycle is discarded.
- Stall without flush: no allocation or RAT change; outputs hold (Wake bits still update per the bypass rule).
- Reset mid-operation restores the initial state regardless of other inputs. Reset has priority over flush.
- Invariant: tail == retire_ptr (mod 32). Pointers are 5 bits and wrap naturally.

Test Plan:
1. Reset, then group Rd=1,2,3,4 with Rs=0 → Phydst 32,33,34,35; all Wake=1; free_count=28; Rename_Stall=0.
2. Intra-group dependency: slot1 Rd=5; slot2 Rs1=5, Rs2=6 → slot2 Src1=32, Wake=0; Src2=6, Wake=1.
3. ALU0 writeback of tag 32 in the rename cycle of a reader of r5 → Src1=32, Src1_Wake=1. A held stalled output also flips to 1 on writeback.
4. Allocate 28 registers; free_count=4, Rename_Stall=0. Allocate 1 more → free_count=3, Rename_Stall=1, and the group is held. A commit of Rdst=1 brings free_count=4 and Rename_Stall=0.
5. Rename r7→32, commit it (pushes 7), rename r7→33, flush → RAT[7]=32, alloc_ptr=1. The next allocation returns 33.
6. Commit with Rdst=0, plus a flush coinciding with a commit of Rdst=3 → the first leaves free_count unchanged; the second gives RAT[3]=Commit_Phy_1 after the flush.
